// File: rtl/bp_trace_decoder_pkg.sv
// rtl/bp_trace_decoder_pkg.sv - Nexus trace packet types and decoder state encoding
package bp_trace_decoder_pkg;

  localparam int nexus_addr_width_gp  = 32;
  localparam int nexus_mcode_width_gp = 6;

  localparam logic [nexus_mcode_width_gp-1:0] NEXUS_MCODE_DIRECT_BRANCH = 6'd3;
  localparam logic [nexus_mcode_width_gp-1:0] NEXUS_MCODE_COMPRESSED    = 6'd33;

  typedef struct packed {
    logic [nexus_mcode_width_gp-1:0] mcode;
    logic [nexus_addr_width_gp-1:0]  addr;
  } nexus_trace_pkt_s;

  typedef enum logic {
    e_trace_unsync = 1'b0,
    e_trace_sync   = 1'b1
  } bp_trace_state_e;

endpackage

// File: rtl/bp_trace_pc_fifo.sv
// rtl/bp_trace_pc_fifo.sv - Power-of-two PC FIFO with registered storage and synchronous clear
module bp_trace_pc_fifo #(
  parameter int width_p = 32,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               valid_o,
  output logic               full_o
);

  localparam int ptr_width_lp = $clog2(els_p);
  typedef logic [ptr_width_lp-1:0] ptr_t;
  typedef logic [ptr_width_lp:0]   cnt_t;
  localparam cnt_t els_lp = cnt_t'(els_p);

  logic [width_p-1:0] mem_r [els_p];
  ptr_t wr_ptr_r, rd_ptr_r;
  cnt_t count_r;
  logic do_push, do_pop;

  assign full_o  = (count_r == els_lp);
  assign valid_o = (count_r != '0);
  assign data_o  = mem_r[rd_ptr_r];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & valid_o;

  // Storage is reset so the head reads zero straight out of reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < els_p; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push) begin
        mem_r[wr_ptr_r] <= data_i;
        wr_ptr_r        <= wr_ptr_r + ptr_t'(1);
      end
      if (do_pop) rd_ptr_r <= rd_ptr_r + ptr_t'(1);
      case ({do_push, do_pop})
        2'b10:   count_r <= count_r + cnt_t'(1);
        2'b01:   count_r <= count_r - cnt_t'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/bp_trace_decoder.sv
// rtl/bp_trace_decoder.sv - Rebuilds absolute committed PCs from a Nexus full/compressed packet stream
module bp_trace_decoder
  import bp_trace_decoder_pkg::*;
#(
  parameter int addr_width_p = 32,
  parameter int fifo_els_p   = 4,
  parameter int cnt_width_p  = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  nexus_trace_pkt_s        trace_pkt_i,
  input  logic                    trace_valid_i,
  output logic                    trace_ready_o,
  input  logic                    flush_i,
  output logic [addr_width_p-1:0] pc_o,
  output logic                    pc_valid_o,
  input  logic                    pc_ready_i,
  output logic                    synced_o,
  output logic [cnt_width_p-1:0]  drop_cnt_o,
  output logic [cnt_width_p-1:0]  err_cnt_o
);

  typedef logic [cnt_width_p-1:0] cnt_t;

  bp_trace_state_e state_r, state_n;
  logic [addr_width_p-1:0] base_r, base_n, pkt_addr, sum, push_data;
  logic ready_en_r, fifo_full, accept, push, drop_inc, err_inc;

  // Holds ready low during reset and raises it on the first edge afterwards.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ready_en_r <= 1'b0;
    else            ready_en_r <= 1'b1;
  end

  assign trace_ready_o = ready_en_r & ~fifo_full & ~flush_i;
  assign accept        = trace_valid_i & trace_ready_o;
  assign pkt_addr      = trace_pkt_i.addr[addr_width_p-1:0];
  assign sum           = base_r + pkt_addr;
  assign synced_o      = (state_r == e_trace_sync);

  always_comb begin
    state_n   = state_r;
    base_n    = base_r;
    push      = 1'b0;
    push_data = pkt_addr;
    drop_inc  = 1'b0;
    err_inc   = 1'b0;
    if (flush_i) begin
      state_n = e_trace_unsync;
    end else if (accept) begin
      case (trace_pkt_i.mcode)
        NEXUS_MCODE_DIRECT_BRANCH: begin
          base_n  = pkt_addr;
          push    = 1'b1;
          state_n = e_trace_sync;
        end
        NEXUS_MCODE_COMPRESSED: begin
          if (state_r == e_trace_sync) begin
            base_n    = sum;
            push      = 1'b1;
            push_data = sum;
          end else begin
            drop_inc = 1'b1;
          end
        end
        default: begin
          // Unknown packet means the base can no longer be trusted.
          err_inc = 1'b1;
          state_n = e_trace_unsync;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= e_trace_unsync;
      base_r     <= '0;
      drop_cnt_o <= '0;
      err_cnt_o  <= '0;
    end else begin
      state_r <= state_n;
      base_r  <= base_n;
      if (drop_inc && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + cnt_t'(1);
      if (err_inc && err_cnt_o != '1)   err_cnt_o  <= err_cnt_o + cnt_t'(1);
    end
  end

  bp_trace_pc_fifo #(
    .width_p (addr_width_p),
    .els_p   (fifo_els_p)
  ) pc_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (flush_i),
    .push_i    (push),
    .data_i    (push_data),
    .pop_i     (pc_ready_i),
    .data_o    (pc_o),
    .valid_o   (pc_valid_o),
    .full_o    (fifo_full)
  );

endmodule

// File: tb/tb_bp_trace_decoder.sv
// tb/tb_bp_trace_decoder.sv - Directed vector bench for bp_trace_decoder
`timescale 1ns/1ps
module tb_bp_trace_decoder;
  import bp_trace_decoder_pkg::*;

  localparam logic [5:0] MC_DIR = 6'd3;
  localparam logic [5:0] MC_CMP = 6'd33;
  localparam logic [5:0] MC_BAD = 6'd0;

  logic clk = 1'b0;
  logic reset_n;
  nexus_trace_pkt_s trace_pkt;
  logic trace_valid, trace_ready, flush, pc_valid, pc_ready, synced;
  logic [31:0] pc;
  logic [15:0] drop_cnt, err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_trace_decoder dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .trace_pkt_i   (trace_pkt),
    .trace_valid_i (trace_valid),
    .trace_ready_o (trace_ready),
    .flush_i       (flush),
    .pc_o          (pc),
    .pc_valid_o    (pc_valid),
    .pc_ready_i    (pc_ready),
    .synced_o      (synced),
    .drop_cnt_o    (drop_cnt),
    .err_cnt_o     (err_cnt)
  );

  typedef struct {
    logic        valid;
    logic [5:0]  mcode;
    logic [31:0] addr;
    logic        exp_pv;
    logic [31:0] exp_pc;
    logic        exp_synced;
    logic [15:0] exp_drop;
    logic [15:0] exp_err;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] m, input logic [31:0] a,
                       input logic rdy, input logic fl);
    trace_valid     = v;
    trace_pkt.mcode = m;
    trace_pkt.addr  = a;
    pc_ready        = rdy;
    flush           = fl;
  endtask

  // Each step: inputs go on 1ns after the edge, outputs are sampled 2ns later.
  task automatic step(input logic v, input logic [5:0] m, input logic [31:0] a,
                      input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    drive(v, m, a, rdy, fl);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    drive(1'b0, MC_DIR, 32'h0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    logic acc5;

    // valid mcode addr | pv pc synced drop err
    vecs[0]  = '{1'b1, MC_DIR, 32'h0000_1000, 1'b0, 32'h0,          1'b0, 16'd0, 16'd0};
    vecs[1]  = '{1'b1, MC_CMP, 32'h0000_0010, 1'b1, 32'h0000_1000, 1'b1, 16'd0, 16'd0};
    vecs[2]  = '{1'b1, MC_DIR, 32'h8000_0000, 1'b1, 32'h0000_1010, 1'b1, 16'd0, 16'd0};
    vecs[3]  = '{1'b0, MC_DIR, 32'h0,         1'b1, 32'h8000_0000, 1'b1, 16'd0, 16'd0};
    vecs[4]  = '{1'b0, MC_DIR, 32'h0,         1'b0, 32'h0,          1'b1, 16'd0, 16'd0};
    vecs[5]  = '{1'b1, MC_DIR, 32'hFFFF_FFF0, 1'b0, 32'h0,          1'b1, 16'd0, 16'd0};
    vecs[6]  = '{1'b1, MC_CMP, 32'h0000_0020, 1'b1, 32'hFFFF_FFF0, 1'b1, 16'd0, 16'd0};
    vecs[7]  = '{1'b0, MC_DIR, 32'h0,         1'b1, 32'h0000_0010, 1'b1, 16'd0, 16'd0};
    vecs[8]  = '{1'b0, MC_DIR, 32'h0,         1'b0, 32'h0,          1'b1, 16'd0, 16'd0};
    vecs[9]  = '{1'b1, MC_DIR, 32'h0000_3000, 1'b0, 32'h0,          1'b1, 16'd0, 16'd0};
    vecs[10] = '{1'b1, MC_BAD, 32'h0000_0000, 1'b1, 32'h0000_3000, 1'b1, 16'd0, 16'd0};
    vecs[11] = '{1'b1, MC_CMP, 32'h0000_0008, 1'b0, 32'h0,          1'b0, 16'd0, 16'd1};
    vecs[12] = '{1'b0, MC_DIR, 32'h0,         1'b0, 32'h0,          1'b0, 16'd1, 16'd1};

    reset_n = 1'b0;
    drive(1'b0, MC_DIR, 32'h0, 1'b1, 1'b0);
    #3;
    check("rst_ready", {31'b0, trace_ready}, 32'd0);
    check("rst_pv", {31'b0, pc_valid}, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_synced", {31'b0, synced}, 32'd0);
    check("rst_cnts", {drop_cnt, err_cnt}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].valid, vecs[i].mcode, vecs[i].addr, 1'b1, 1'b0);
      check($sformatf("v%0d_ready", i), {31'b0, trace_ready}, 32'd1);
      check($sformatf("v%0d_pv", i), {31'b0, pc_valid}, {31'b0, vecs[i].exp_pv});
      if (vecs[i].exp_pv) check($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("v%0d_synced", i), {31'b0, synced}, {31'b0, vecs[i].exp_synced});
      check($sformatf("v%0d_drop", i), {16'b0, drop_cnt}, {16'b0, vecs[i].exp_drop});
      check($sformatf("v%0d_err", i), {16'b0, err_cnt}, {16'b0, vecs[i].exp_err});
    end

    // Compressed packets before any full address are dropped.
    do_reset();
    step(1'b1, MC_CMP, 32'h10, 1'b1, 1'b0);
    step(1'b1, MC_CMP, 32'h10, 1'b1, 1'b0);
    check("drop_pv1", {31'b0, pc_valid}, 32'd0);
    step(1'b1, MC_DIR, 32'h2000, 1'b1, 1'b0);
    check("drop_pv2", {31'b0, pc_valid}, 32'd0);
    step(1'b0, MC_DIR, 32'h0, 1'b1, 1'b0);
    check("drop_cnt", {16'b0, drop_cnt}, 32'd2);
    check("drop_pc", pc, 32'h2000);
    check("drop_pvv", {31'b0, pc_valid}, 32'd1);
    check("drop_synced", {31'b0, synced}, 32'd1);

    // Fill the FIFO with the sink stalled; the fifth packet must wait.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step(1'b1, MC_DIR, 32'h100 + c, 1'b0, 1'b0);
      check($sformatf("fill%0d_ready", c), {31'b0, trace_ready}, 32'd1);
    end
    step(1'b1, MC_DIR, 32'h104, 1'b0, 1'b0);
    check("full_ready", {31'b0, trace_ready}, 32'd0);
    check("full_pc", pc, 32'h100);
    step(1'b1, MC_DIR, 32'h104, 1'b0, 1'b0);
    check("hold_pc", pc, 32'h100);
    step(1'b1, MC_DIR, 32'h104, 1'b1, 1'b0);
    check("full_pop_ready", {31'b0, trace_ready}, 32'd0);
    check("drain_pc0", pc, 32'h100);
    got = 1;
    acc5 = 1'b0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      step(~acc5, MC_DIR, 32'h104, 1'b1, 1'b0);
      if (pc_valid) begin
        check($sformatf("drain_pc%0d", got), pc, 32'h100 + got);
        got++;
      end
      if (trace_valid && trace_ready) acc5 = 1'b1;
    end
    check("drain_count", got, 32'd5);

    // Flush with PCs buffered, then asynchronous reset mid-stream.
    do_reset();
    step(1'b1, MC_CMP, 32'h4, 1'b0, 1'b0);
    step(1'b1, MC_DIR, 32'h10, 1'b0, 1'b0);
    step(1'b1, MC_DIR, 32'h20, 1'b0, 1'b0);
    step(1'b1, MC_DIR, 32'h30, 1'b0, 1'b0);
    step(1'b1, MC_DIR, 32'h50, 1'b0, 1'b1);
    check("flush_ready", {31'b0, trace_ready}, 32'd0);
    check("flush_pv_before", {31'b0, pc_valid}, 32'd1);
    step(1'b0, MC_DIR, 32'h0, 1'b0, 1'b0);
    check("flush_pv", {31'b0, pc_valid}, 32'd0);
    check("flush_synced", {31'b0, synced}, 32'd0);
    check("flush_cnts", {drop_cnt, err_cnt}, {16'd1, 16'd0});
    step(1'b1, MC_DIR, 32'h40, 1'b0, 1'b0);
    check("post_flush_ready", {31'b0, trace_ready}, 32'd1);
    step(1'b0, MC_DIR, 32'h0, 1'b0, 1'b0);
    check("post_flush_pc", pc, 32'h40);
    check("post_flush_pv", {31'b0, pc_valid}, 32'd1);
    #0.5;
    reset_n = 1'b0;
    #0.5;
    check("arst_pv", {31'b0, pc_valid}, 32'd0);
    check("arst_pc", pc, 32'd0);
    check("arst_synced", {31'b0, synced}, 32'd0);
    check("arst_ready", {31'b0, trace_ready}, 32'd0);
    check("arst_cnts", {drop_cnt, err_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_trace_decoder.md
Name: bp_trace_decoder

Overview:
- Receive-side counterpart of bp_trace_encoder. Consumes the Nexus trace packet stream (nexus_trace_pkt_s, valid/ready) and reconstructs the absolute committed-PC sequence.
- Full packets (NEXUS_MCODE_DIRECT_BRANCH) carry an absolute address. Compressed packets (NEXUS_MCODE_COMPRESSED) carry a delta from the last reconstructed PC.
- Reconstructed PCs are buffered in a small FIFO with a valid/ready output. Sits between trace transport and the host-side trace sink / checker.

Parameters:
- addr_width_p, 32, width of the PC and of the packet addr field.
- fifo_els_p, 4, output PC FIFO depth; power of two, ≥ 2.
- cnt_width_p, 16, width of the drop and error counters.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- trace_pkt_i  in  $bits(nexus_trace_pkt_s)  incoming trace packet (mcode, addr).
- trace_valid_i  in  1  packet valid.
- trace_ready_o  out  1  decoder can accept a packet.
- flush_i  in  1  synchronous resync request: drop buffered PCs and lose sync.
- pc_o  out  addr_width_p  reconstructed PC at FIFO head.
- pc_valid_o  out  1  pc_o valid.
- pc_ready_i  in  1  sink accepts pc_o.
- synced_o  out  1  decoder holds a valid PC base.
- drop_cnt_o  out  cnt_width_p  compressed packets dropped while unsynced (saturating).
- err_cnt_o  out  cnt_width_p  packets with unknown mcode (saturating).

Behaviour:
- Reset (reset_n_i=0, asynchronous): state=UNSYNC, base PC=0, FIFO empty, pc_o=0, pc_valid_o=0, trace_ready_o=0, synced_o=0, both counters=0. After deassertion, trace_ready_o=1 from the first clock edge.
- Handshakes:
  - Accept = trace_valid_i & trace_ready_o.
  - trace_ready_o = !fifo_full & !flush_i, registered-state based. No combinational path from pc_ready_i.
  - A full FIFO stalls input even if a pop occurs in the same cycle.
  - Pop = pc_valid_o & pc_ready_i.
- FSM, two states:
  - UNSYNC:
    - accepted DIRECT_BRANCH → base=addr, push addr, go SYNC.
    - accepted COMPRESSED → no push, drop_cnt_o++.
    - unknown mcode → err_cnt_o++, stay UNSYNC.
  - SYNC:
    - DIRECT_BRANCH → base=addr, push addr.
    - COMPRESSED → new=base+addr mod 2^addr_width_p (unsigned, wrap-around, no error); base=new, push new.
    - unknown mcode → err_cnt_o++, no push, go UNSYNC (base no longer trusted).
- Latency: an accepted packet's PC is visible on pc_o with pc_valid_o=1 on the next cycle when the FIFO was empty (one registered stage). Otherwise it appears in FIFO order; order is strictly preserved.
- Back-to-back compressed packets chain: each uses the base updated by the previous accepted packet in the prior cycle, with no bubble required.
- flush_i (synchronous, highest priority):
  - that cycle: no accept, no pop effect; FIFO cleared.
  - next cycle: state=UNSYNC, pc_valid_o=0.
  - counters are not cleared.
- Counters saturate at all-ones and never wrap.
- synced_o = (state==SYNC), registered.
- FIFO full: trace_ready_o=0; pc_o and the head entry are held stable while pc_ready_i=0.
- Simultaneous push and pop with the FIFO non-empty and not full: both occur and the count is unchanged.

Decomposition:
- Shared package/header (bp_nexus_defines.svh): nexus_trace_pkt_s, NEXUS_MCODE_COMPRESSED, NEXUS_MCODE_DIRECT_BRANCH. Add a decoder state enum (e_trace_unsync, e_trace_sync) there.
- One sub-module: bp_trace_pc_fifo. Parameterised width/depth, registered-output FIFO with valid/ready, full/empty and synchronous clear. Async active-low reset.
- Top-level holds the FSM, base register, adder and counters.

Test Plan:
1. Reset, then packets DIRECT 0x1000, COMPRESSED 0x10, DIRECT 0x80000000 on consecutive cycles, pc_ready_i=1 → pc_o = 0x1000, 0x1010, 0x80000000 on three consecutive cycles starting one cycle after the first accept; synced_o=1 after the first accept.
2. Out of reset, COMPRESSED 0x10 twice, then DIRECT 0x2000 → no PC output for the compressed packets; drop_cnt_o=2; then pc_o=0x2000 and synced_o=1.
3. DIRECT 0xFFFFFFF0 then COMPRESSED 0x20 → pc_o 0xFFFFFFF0 then 0x00000010; wrap is not flagged.
4. pc_ready_i=0, then 5 DIRECT packets 0x100..0x104 with fifo_els_p=4 → trace_ready_o drops after 4 accepts and the 5th is stalled. Raise pc_ready_i → output 0x100..0x104 in order, none lost.
5. SYNC with base 0x3000, then unknown mcode, then COMPRESSED 0x8 → err_cnt_o=1, synced_o=0, drop_cnt_o increments, no PC output.
6. 3 PCs buffered, assert flush_i one cycle → pc_valid_o=0 next cycle, synced_o=0, counters unchanged. Async reset asserted mid-stream → all outputs zero immediately, without waiting for a clock edge.
